// File: rtl/hitmark_slot_pkg.sv
// Shared definitions for the hit-mark sprite slot: register map and sequencer states.
// Imported by the slot decode and by the hardware write sequencer.
package hitmark_slot_pkg;

  localparam logic [1:0] REG_BYPASS = 2'd0;
  localparam logic [1:0] REG_X0     = 2'd1;
  localparam logic [1:0] REG_Y0     = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int REG_SPACE_BIT = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_X,
    ST_WR_Y,
    ST_WR_CTRL,
    ST_WR_SHOW,
    ST_HOLD,
    ST_WR_HIDE
  } state_e;

  function automatic logic [13:0] reg_addr(input logic [1:0] idx);
    logic [13:0] a;
    a = '0;
    a[REG_SPACE_BIT] = 1'b1;
    a[1:0] = idx;
    return a;
  endfunction

endpackage

// File: rtl/hitmark_slot_sequencer.sv
// Drives the hit-mark sprite slot on a hit: place, show, animate over frames, then hide.
// Bus outputs are registered and decoded from the next state so each write lands in its state's cycle.
module hitmark_slot_sequencer
  import hitmark_slot_pkg::*;
#(
  parameter int         NUM_STEPS       = 4,
  parameter int         FRAMES_PER_STEP = 6,
  parameter logic [4:0] CTRL_BASE       = 5'b00100,
  parameter int         OFFSET          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] hit_x,
  input  logic [10:0] hit_y,
  input  logic        abort,
  input  logic        frame_tick,
  output logic        cs,
  output logic        write,
  output logic [13:0] addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done
);

  state_e      state_q, state_d;
  logic [4:0]  step_q, step_d;
  logic [7:0]  frame_q, frame_d;
  logic [10:0] hy_q, hy_d;
  logic        cs_q, cs_d;
  logic [13:0] addr_q, addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        last_step, frame_end;

  function automatic logic [10:0] sat(input logic [10:0] v);
    return (v < 11'(OFFSET)) ? 11'd0 : v - 11'(OFFSET);
  endfunction

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    frame_d   = '0;
    hy_d      = hy_q;
    last_step = (step_q >= 5'(NUM_STEPS - 1));
    frame_end = (frame_q == 8'(FRAMES_PER_STEP - 1));
    if (start) begin
      state_d = ST_WR_X;
      step_d  = '0;
      hy_d    = hit_y;
    end else if (abort && state_q != ST_IDLE && state_q != ST_WR_HIDE) begin
      state_d = ST_WR_HIDE;
    end else begin
      unique case (state_q)
        ST_WR_X:    state_d = ST_WR_Y;
        ST_WR_Y:    state_d = ST_WR_CTRL;
        // Only the first ctrl write (step 0) is followed by the show write.
        ST_WR_CTRL: state_d = (step_q == '0) ? ST_WR_SHOW : ST_HOLD;
        ST_WR_SHOW: state_d = ST_HOLD;
        ST_HOLD: begin
          frame_d = frame_q;
          if (frame_tick) begin
            if (frame_end) begin
              frame_d = '0;
              if (last_step) begin
                state_d = ST_WR_HIDE;
              end else begin
                step_d  = step_q + 5'd1;
                state_d = ST_WR_CTRL;
              end
            end else begin
              frame_d = frame_q + 8'd1;
            end
          end
        end
        ST_WR_HIDE: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cs_d      = 1'b0;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    unique case (state_d)
      ST_WR_X: begin
        cs_d      = 1'b1;
        addr_d    = reg_addr(REG_X0);
        wr_data_d = {21'd0, sat(hit_x)};
      end
      ST_WR_Y: begin
        cs_d      = 1'b1;
        addr_d    = reg_addr(REG_Y0);
        wr_data_d = {21'd0, sat(hy_q)};
      end
      ST_WR_CTRL: begin
        cs_d      = 1'b1;
        addr_d    = reg_addr(REG_CTRL);
        wr_data_d = {27'd0, 5'(CTRL_BASE + step_d)};
      end
      ST_WR_SHOW: begin
        cs_d      = 1'b1;
        addr_d    = reg_addr(REG_BYPASS);
        wr_data_d = 32'd0;
      end
      ST_WR_HIDE: begin
        cs_d      = 1'b1;
        addr_d    = reg_addr(REG_BYPASS);
        wr_data_d = 32'd1;
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_WR_HIDE) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      frame_q   <= '0;
      hy_q      <= '0;
      cs_q      <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      frame_q   <= frame_d;
      hy_q      <= hy_d;
      cs_q      <= cs_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign cs      = cs_q;
  assign write   = cs_q;
  assign addr    = addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_hitmark_slot_sequencer.sv
// Bench for hitmark_slot_sequencer: directed vector table, async reset sequence,
// then random traffic against a write-queue reference model.
module tb_hitmark_slot_sequencer;

  localparam int         NS  = 4;
  localparam int         FPS = 6;
  localparam int         OFF = 16;
  localparam logic [4:0] CB  = 5'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, abort = 1'b0, frame_tick = 1'b0;
  logic [10:0] hit_x = '0, hit_y = '0;
  logic        cs, write, busy, done;
  logic [13:0] addr;
  logic [31:0] wr_data;

  int errors = 0;
  int checks = 0;

  hitmark_slot_sequencer #(
    .NUM_STEPS(NS), .FRAMES_PER_STEP(FPS), .CTRL_BASE(CB), .OFFSET(OFF)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hit_x(hit_x), .hit_y(hit_y),
    .abort(abort), .frame_tick(frame_tick), .cs(cs), .write(write),
    .addr(addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [10:0] hx, hy;
    logic        ab, tk;
    logic        cs;
    logic [13:0] addr;
    logic [31:0] data;
    logic        busy, done;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, input logic [10:0] hx, input logic [10:0] hy,
                     input logic ab, input logic tk, input logic ecs, input logic [13:0] ea,
                     input logic [31:0] ed, input logic eb, input logic edn, input string nm);
    vec_t v;
    v.st = st; v.hx = hx; v.hy = hy; v.ab = ab; v.tk = tk;
    v.cs = ecs; v.addr = ea; v.data = ed; v.busy = eb; v.done = edn; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic hold(input int n, input logic [13:0] ea, input logic [31:0] ed, input string nm);
    for (int k = 0; k < n; k++) add(0, 0, 0, 0, 1, 0, ea, ed, 1, 0, nm);
  endtask

  task automatic check_out(input string nm, input logic ecs, input logic [13:0] ea,
                           input logic [31:0] ed, input logic eb, input logic edn);
    checks++;
    if (cs !== ecs || write !== ecs || addr !== ea || wr_data !== ed || busy !== eb || done !== edn) begin
      errors++;
      $display("FAIL %s: got cs=%b write=%b addr=%h data=%h busy=%b done=%b, expected cs=%b addr=%h data=%h busy=%b done=%b",
               nm, cs, write, addr, wr_data, busy, done, ecs, ea, ed, eb, edn);
    end
  endtask

  task automatic apply(input logic st, input logic [10:0] hx, input logic [10:0] hy,
                       input logic ab, input logic tk);
    start = st; hit_x = hx; hit_y = hy; abort = ab; frame_tick = tk;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of pending slot writes, one issued per cycle.
  typedef struct packed { logic [13:0] a; logic [31:0] d; } wr_t;
  wr_t         mq[$];
  int          m_step, m_cnt;
  bit          m_act, m_hide_out, m_prev_cs;
  logic        e_cs, e_busy, e_done;
  logic [13:0] e_addr;
  logic [31:0] e_data;

  function automatic logic [31:0] satsub(input int v);
    return (v < OFF) ? 32'd0 : 32'(v - OFF);
  endfunction

  function automatic wr_t mk(input int a, input logic [31:0] d);
    wr_t w;
    w.a = 14'(a); w.d = d;
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_step = 0; m_cnt = 0; m_act = 0; m_hide_out = 0; m_prev_cs = 0;
    e_cs = 0; e_busy = 0; e_done = 0; e_addr = '0; e_data = '0;
  endtask

  task automatic model_step(input logic st, input int hx, input int hy, input logic ab, input logic tk);
    wr_t w;
    e_done = 0;
    if (st) begin
      mq.delete();
      mq.push_back(mk('h2001, satsub(hx)));
      mq.push_back(mk('h2002, satsub(hy)));
      mq.push_back(mk('h2003, 32'(int'(CB) % 32)));
      mq.push_back(mk('h2000, 32'd0));
      m_step = 0; m_cnt = 0; m_act = 1;
    end else if (m_hide_out) begin
      m_act = 0;
      e_done = 1;
    end else if (m_act && ab) begin
      mq.delete();
      mq.push_back(mk('h2000, 32'd1));
    end else if (m_act && !m_prev_cs && mq.size() == 0 && tk) begin
      m_cnt++;
      if (m_cnt == FPS) begin
        m_cnt = 0;
        if (m_step < NS - 1) begin
          m_step++;
          mq.push_back(mk('h2003, 32'((int'(CB) + m_step) % 32)));
        end else begin
          mq.push_back(mk('h2000, 32'd1));
        end
      end
    end
    if (mq.size() > 0) begin
      w = mq.pop_front();
      e_cs = 1; e_addr = w.a; e_data = w.d;
      m_hide_out = (w.a == 14'h2000 && w.d == 32'd1);
      m_cnt = 0;
    end else begin
      e_cs = 0;
      m_hide_out = 0;
    end
    m_prev_cs = e_cs;
    e_busy = m_act;
  endtask

  initial begin
    logic        st, ab, tk;
    logic [10:0] hx, hy;

    // Normal run with ticks also offered during write states (must be ignored).
    add(1, 100, 50, 0, 0, 1, 'h2001, 84, 1, 0, "norm_x0");
    add(0, 0, 0, 0, 1, 1, 'h2002, 34, 1, 0, "norm_y0");
    add(0, 0, 0, 0, 1, 1, 'h2003, 4, 1, 0, "norm_ctrl0");
    add(0, 0, 0, 0, 1, 1, 'h2000, 0, 1, 0, "norm_show");
    add(0, 0, 0, 0, 1, 0, 'h2000, 0, 1, 0, "norm_tick_in_show");
    hold(5, 'h2000, 0, "norm_hold0");
    add(0, 0, 0, 0, 1, 1, 'h2003, 5, 1, 0, "norm_ctrl5");
    add(0, 0, 0, 0, 1, 0, 'h2003, 5, 1, 0, "norm_tick_in_ctrl");
    hold(5, 'h2003, 5, "norm_hold1");
    add(0, 0, 0, 0, 1, 1, 'h2003, 6, 1, 0, "norm_ctrl6");
    add(0, 0, 0, 0, 1, 0, 'h2003, 6, 1, 0, "norm_tick_in_ctrl");
    hold(5, 'h2003, 6, "norm_hold2");
    add(0, 0, 0, 0, 1, 1, 'h2003, 7, 1, 0, "norm_ctrl7");
    add(0, 0, 0, 0, 1, 0, 'h2003, 7, 1, 0, "norm_tick_in_ctrl");
    hold(5, 'h2003, 7, "norm_hold3");
    add(0, 0, 0, 0, 1, 1, 'h2000, 1, 1, 0, "norm_hide");
    add(0, 0, 0, 0, 1, 0, 'h2000, 1, 0, 1, "norm_done");
    add(0, 0, 0, 0, 0, 0, 'h2000, 1, 0, 0, "norm_idle");
    add(0, 0, 0, 1, 1, 0, 'h2000, 1, 0, 0, "abort_in_idle");
    // Saturation, then abort during step 1.
    add(1, 5, 0, 0, 0, 1, 'h2001, 0, 1, 0, "sat_x0");
    add(0, 0, 0, 0, 0, 1, 'h2002, 0, 1, 0, "sat_y0");
    add(0, 0, 0, 0, 0, 1, 'h2003, 4, 1, 0, "sat_ctrl0");
    add(0, 0, 0, 0, 0, 1, 'h2000, 0, 1, 0, "sat_show");
    add(0, 0, 0, 0, 0, 0, 'h2000, 0, 1, 0, "sat_hold_entry");
    hold(5, 'h2000, 0, "sat_hold0");
    add(0, 0, 0, 0, 1, 1, 'h2003, 5, 1, 0, "sat_ctrl5");
    add(0, 0, 0, 0, 0, 0, 'h2003, 5, 1, 0, "sat_hold1");
    add(0, 0, 0, 1, 0, 1, 'h2000, 1, 1, 0, "abort_hide");
    add(0, 0, 0, 0, 0, 0, 'h2000, 1, 0, 1, "abort_done");
    add(0, 0, 0, 0, 0, 0, 'h2000, 1, 0, 0, "abort_idle_after");
    // Restart during HOLD of step 2, with abort in the same cycle.
    add(1, 1000, 1000, 0, 0, 1, 'h2001, 984, 1, 0, "rs_x0");
    add(0, 0, 0, 0, 0, 1, 'h2002, 984, 1, 0, "rs_y0");
    add(0, 0, 0, 0, 0, 1, 'h2003, 4, 1, 0, "rs_ctrl0");
    add(0, 0, 0, 0, 0, 1, 'h2000, 0, 1, 0, "rs_show");
    add(0, 0, 0, 0, 0, 0, 'h2000, 0, 1, 0, "rs_hold_entry");
    hold(5, 'h2000, 0, "rs_hold0");
    add(0, 0, 0, 0, 1, 1, 'h2003, 5, 1, 0, "rs_ctrl5");
    add(0, 0, 0, 0, 0, 0, 'h2003, 5, 1, 0, "rs_hold1");
    hold(5, 'h2000 + 3, 5, "rs_hold1");
    add(0, 0, 0, 0, 1, 1, 'h2003, 6, 1, 0, "rs_ctrl6");
    add(0, 0, 0, 0, 0, 0, 'h2003, 6, 1, 0, "rs_hold2");
    add(0, 0, 0, 0, 1, 0, 'h2003, 6, 1, 0, "rs_hold2_tick");
    add(1, 300, 200, 1, 1, 1, 'h2001, 284, 1, 0, "restart_x0");
    add(0, 0, 0, 0, 0, 1, 'h2002, 184, 1, 0, "restart_y0");
    add(0, 0, 0, 0, 0, 1, 'h2003, 4, 1, 0, "restart_ctrl0");
    add(0, 0, 0, 0, 0, 1, 'h2000, 0, 1, 0, "restart_show");
    add(0, 0, 0, 0, 0, 0, 'h2000, 0, 1, 0, "restart_no_done");
    add(0, 0, 0, 0, 1, 0, 'h2000, 0, 1, 0, "restart_hold");

    #12;
    check_out("reset_values", 0, '0, '0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i].st, tbl[i].hx, tbl[i].hy, tbl[i].ab, tbl[i].tk);
      check_out(tbl[i].name, tbl[i].cs, tbl[i].addr, tbl[i].data, tbl[i].busy, tbl[i].done);
    end

    // Asynchronous reset mid-HOLD clears outputs without waiting for a clock edge.
    apply(0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_out("async_reset", 0, '0, '0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    apply(1, 700, 40, 0, 0);
    check_out("post_reset_x0", 1, 'h2001, 684, 1, 0);
    apply(0, 0, 0, 0, 0);
    check_out("post_reset_y0", 1, 'h2002, 24, 1, 0);
    apply(0, 0, 0, 0, 0);
    check_out("post_reset_ctrl0", 1, 'h2003, 4, 1, 0);
    apply(0, 0, 0, 0, 0);
    check_out("post_reset_show", 1, 'h2000, 0, 1, 0);

    // Random traffic against the reference model.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      st = ($urandom_range(0, 99) < 2);
      ab = ($urandom_range(0, 99) < 2);
      tk = ($urandom_range(0, 99) < 40);
      hx = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 20)) : 11'($urandom_range(0, 2047));
      hy = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 20)) : 11'($urandom_range(0, 2047));
      apply(st, hx, hy, ab, tk);
      model_step(st, int'(hx), int'(hy), ab, tk);
      check_out($sformatf("rand_%0d", i), e_cs, e_addr, e_data, e_busy, e_done);
    end
    apply(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
